block_gpu_axil_slave: RTL and testbench
=======================================

Name: block_gpu_axil_slave

Overview:
- AXI4-Lite responder (slave) register file for the BLOCK_GPU peripheral; the target end of the AXI4-Lite master on the S00_AXI port.
- Holds four 32-bit read/write control registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Drives the register contents and per-register write pulses into the block-drawing GPU core.
- Single outstanding write and single outstanding read; AW and W channels are accepted independently, in either order.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; one clock; reset is asynchronous and active-low
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1  write address valid
- s00_axi_awready  out  1  write address ready
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid  in  1  write data valid
- s00_axi_wready  out  1  write data ready
- s00_axi_bresp  out  2  write response, always 2'b00
- s00_axi_bvalid  out  1  write response valid
- s00_axi_bready  in  1  write response ready
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1  read address valid
- s00_axi_arready  out  1  read address ready
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response, always 2'b00
- s00_axi_rvalid  out  1  read data valid
- s00_axi_rready  in  1  read data ready
- reg0_out..reg3_out  out  32 each  current register values, to the GPU core
- reg_wr_pulse  out  4  one-cycle pulse, bit n set on a write commit to register n

Behaviour:
- Reset (async assert, sync release):
  - Registers, rdata, all valid/ready outputs and reg_wr_pulse are 0.
  - AWREADY, WREADY and ARREADY rise on the first clock edge after release.
- Write FSM states:
  - W_IDLE: neither AW nor W latched.
  - W_HAVE_AW: AW latched, W not yet.
  - W_HAVE_W: W latched, AW not yet.
  - W_COMMIT: both latched.
  - W_RESP: BVALID high.
- Write handshakes:
  - AWREADY=1 in W_IDLE and W_HAVE_W; WREADY=1 in W_IDLE and W_HAVE_AW. Both are 0 otherwise.
  - A channel handshake latches its address or data+strobe.
  - AW and W in the same cycle: W_IDLE goes directly to W_COMMIT.
- Write commit:
  - In W_COMMIT, the register selected by awaddr[3:2] updates byte-wise: byte k is written only if wstrb[k]=1.
  - reg_wr_pulse[sel] is high for that one cycle.
  - The next state is W_RESP.
- Write latency: a simultaneous AW+W handshake at edge E0 gives the register update at E1 and BVALID=1 from E1.
- Write response:
  - BVALID is held until BREADY. The B handshake returns the FSM to W_IDLE.
  - BREADY already high gives BVALID for exactly one cycle.
- wstrb=0: no register change and no pulse, but the full response is still issued with BRESP=OKAY.
- Address decode: addr[1:0] is ignored. Every address decodes to one of the four registers; no SLVERR or DECERR is ever returned.
- Read path, states R_IDLE and R_DATA:
  - ARREADY=1 only in R_IDLE.
  - The AR handshake at edge E0 captures the selected register into rdata at E0; RVALID=1 from E0 onwards.
  - RVALID and rdata are held stable until RREADY. The handshake returns to R_IDLE, with ARREADY high the following cycle.
- Read/write collision: when the read capture edge equals the write commit edge on the same register, rdata returns the OLD value. The next read returns the new value.
- Concurrency: the read and write paths are fully independent and may be busy simultaneously.
- Reset mid-transaction: all latched AW/W/AR state and pending B/R responses are discarded. After release, the registers read 0.
- reg_out timing: regN_out equals the register flop, so new values are visible one cycle after the W_COMMIT cycle.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, each with BREADY=1, then four reads -> each BRESP=00; reads return 0x1, 0x2, 0x3, 0x4; reg_wr_pulse shows 0001, 0010, 0100, 1000 in turn.
- Write 0xFFFFFFFF to 0x4, then write 0x000000AA to 0x4 with wstrb=4'b0001 -> read of 0x4 returns 0xFFFFFFAA.
- AW for 0x8 presented 3 cycles before W (0xDEADBEEF); separately, W for 0xC presented before its AW -> both complete with BVALID after the second channel's handshake; readback matches.
- BREADY held low for 5 cycles after BVALID -> BVALID stays high and AWREADY/WREADY stay 0; a new AWVALID is not accepted until the B handshake.
- Same-edge write commit to 0x0 (0x55) and AR capture of 0x0 (old value 0x1), with RREADY low for 4 cycles -> rdata=0x1 stays stable until RREADY; the next read returns 0x55.
- Assert ARESETN low while BVALID and RVALID are pending -> all outputs go to 0 immediately; after release all registers read 0 and AWREADY/WREADY/ARREADY are high one edge later.

Source files
------------

// File: rtl/block_gpu_axil_slave.sv
// AXI4-Lite register file for the BLOCK_GPU peripheral.
// Four 32-bit control registers, independent write and read paths,
// AW/W accepted in either order, one outstanding transaction per path.
module block_gpu_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
    output logic [3:0]                        reg_wr_pulse
);

    localparam int unsigned DATA_W   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    wstate_t                         wstate;
    rstate_t                         rstate;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [SEL_W-1:0]                aw_sel;
    logic [DATA_W-1:0]               wdata_q;
    logic [STRB_W-1:0]               wstrb_q;

    logic                            aw_hs;
    logic                            w_hs;
    logic                            ar_hs;
    logic                            b_hs;
    logic                            r_hs;
    logic                            commit_go;
    logic [SEL_W-1:0]                sel_next;
    logic [STRB_W-1:0]               strb_next;
    logic [SEL_W-1:0]                ar_sel;

    // Protection bits and the byte offset within a register carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Channel handshakes and the address/strobe that the commit will use.
    always_comb begin
        aw_hs     = s00_axi_awvalid & s00_axi_awready;
        w_hs      = s00_axi_wvalid & s00_axi_wready;
        ar_hs     = s00_axi_arvalid & s00_axi_arready;
        b_hs      = s00_axi_bvalid & s00_axi_bready;
        r_hs      = s00_axi_rvalid & s00_axi_rready;
        sel_next  = aw_hs ? s00_axi_awaddr[3:2] : aw_sel;
        strb_next = w_hs ? s00_axi_wstrb : wstrb_q;
        ar_sel    = s00_axi_araddr[3:2];
        commit_go = 1'b0;
        case (wstate)
            W_IDLE:    commit_go = aw_hs & w_hs;
            W_HAVE_AW: commit_go = w_hs;
            W_HAVE_W:  commit_go = aw_hs;
            default:   commit_go = 1'b0;
        endcase
    end

    // Write FSM: collects AW and W in any order, commits, then holds BVALID.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wstate          <= W_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            reg_wr_pulse    <= '0;
            aw_sel          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (aw_hs) begin
                aw_sel <= s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
            if (commit_go) begin
                // Pulse spans the commit cycle; a zero strobe writes nothing.
                wstate          <= W_COMMIT;
                s00_axi_awready <= 1'b0;
                s00_axi_wready  <= 1'b0;
                if (|strb_next) begin
                    reg_wr_pulse <= 4'b0001 << sel_next;
                end
            end else begin
                case (wstate)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wstate          <= W_HAVE_AW;
                            s00_axi_awready <= 1'b0;
                            s00_axi_wready  <= 1'b1;
                        end else if (w_hs) begin
                            wstate          <= W_HAVE_W;
                            s00_axi_awready <= 1'b1;
                            s00_axi_wready  <= 1'b0;
                        end else begin
                            s00_axi_awready <= 1'b1;
                            s00_axi_wready  <= 1'b1;
                        end
                    end
                    W_HAVE_AW: begin
                        s00_axi_awready <= 1'b0;
                        s00_axi_wready  <= 1'b1;
                    end
                    W_HAVE_W: begin
                        s00_axi_awready <= 1'b1;
                        s00_axi_wready  <= 1'b0;
                    end
                    W_COMMIT: begin
                        wstate         <= W_RESP;
                        s00_axi_bvalid <= 1'b1;
                    end
                    W_RESP: begin
                        if (b_hs) begin
                            wstate          <= W_IDLE;
                            s00_axi_bvalid  <= 1'b0;
                            s00_axi_awready <= 1'b1;
                            s00_axi_wready  <= 1'b1;
                        end
                    end
                    default: begin
                        wstate          <= W_IDLE;
                        s00_axi_awready <= 1'b0;
                        s00_axi_wready  <= 1'b0;
                        s00_axi_bvalid  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register file: byte-wise update of the selected register in the commit cycle.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            regs <= '0;
        end else if (wstate == W_COMMIT) begin
            for (int unsigned k = 0; k < STRB_W; k++) begin
                if (wstrb_q[k]) begin
                    regs[aw_sel][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    // Read FSM: capture on the AR handshake, hold RVALID/RDATA until RREADY.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rstate          <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate          <= R_DATA;
                        s00_axi_rdata   <= regs[ar_sel];
                        s00_axi_rvalid  <= 1'b1;
                        s00_axi_arready <= 1'b0;
                    end else begin
                        s00_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rstate          <= R_IDLE;
                        s00_axi_rvalid  <= 1'b0;
                        s00_axi_arready <= 1'b1;
                    end
                end
                default: begin
                    rstate          <= R_IDLE;
                    s00_axi_rvalid  <= 1'b0;
                    s00_axi_arready <= 1'b0;
                end
            endcase
        end
    end

    // Every address decodes to a register, so responses are always OKAY.
    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    // Register contents straight to the GPU core.
    assign reg0_out = regs[0];
    assign reg1_out = regs[1];
    assign reg2_out = regs[2];
    assign reg3_out = regs[3];

endmodule

// File: tb/tb_block_gpu_axil_slave.sv
// Directed self-checking bench for block_gpu_axil_slave.
module tb_block_gpu_axil_slave;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] reg0_out;
    logic [31:0] reg1_out;
    logic [31:0] reg2_out;
    logic [31:0] reg3_out;
    logic [3:0]  reg_wr_pulse;

    int checks;
    int failures;

    block_gpu_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .reg0_out       (reg0_out),
        .reg1_out       (reg1_out),
        .reg2_out       (reg2_out),
        .reg3_out       (reg3_out),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] get_reg(input int i);
        case (i)
            0:       return reg0_out;
            1:       return reg1_out;
            2:       return reg2_out;
            default: return reg3_out;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Simultaneous AW+W write with BREADY high; reports OR of pulses seen and BRESP.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [3:0] pulse,
                            output logic [1:0] resp, output bit ok);
        ok = 1'b0;
        pulse = 4'b0000;
        resp = 2'b11;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulse = pulse | reg_wr_pulse;
            if (bvalid) begin
                resp = bresp;
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    // Single read with RREADY high.
    task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                           output bit ok);
        ok = 1'b0;
        data = 32'hxxxxxxxx;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                data = rdata;
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshake: got aw/w/ar/b/r=%b expected 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if (rdata !== 32'h0 || reg_wr_pulse !== 4'h0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h pulse=%b expected 0/0", rdata, reg_wr_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (get_reg(i) !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h expected 00000000", i, get_reg(i));
            end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready_before_edge: got %b expected 000", {awready, wready, arready});
        end
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready_after_edge: got %b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_latency();
        tick();
        awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_wr_pulse !== 4'b0001 || bvalid !== 1'b0 || reg0_out !== 32'h0) begin
            failures++;
            $display("FAIL latency_commit: got pulse=%b bvalid=%b reg0=%h expected 0001/0/00000000",
                     reg_wr_pulse, bvalid, reg0_out);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || reg0_out !== 32'h77 || reg_wr_pulse !== 4'b0) begin
            failures++;
            $display("FAIL latency_resp: got bvalid=%b bresp=%b reg0=%h pulse=%b expected 1/00/00000077/0000",
                     bvalid, bresp, reg0_out, reg_wr_pulse);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            failures++;
            $display("FAIL latency_single_bvalid: got bvalid=%b awready=%b wready=%b expected 0/1/1",
                     bvalid, awready, wready);
        end
    endtask

    task automatic test_sequential();
        logic [3:0]  pulse;
        logic [1:0]  resp;
        logic [31:0] data;
        bit          ok;
        tick();
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), 32'(i + 1), 4'hF, pulse, resp, ok);
            checks++;
            if (!ok || resp !== 2'b00 || pulse !== (4'b0001 << i)) begin
                failures++;
                $display("FAIL seq_write%0d: got ok=%0d bresp=%b pulse=%b expected 1/00/%b",
                         i, ok, resp, pulse, 4'b0001 << i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), data, ok);
            checks++;
            if (!ok || data !== 32'(i + 1)) begin
                failures++;
                $display("FAIL seq_read%0d: got ok=%0d data=%h expected %h", i, ok, data, 32'(i + 1));
            end
        end
    endtask

    task automatic test_strobe();
        logic [3:0]  pulse;
        logic [1:0]  resp;
        logic [31:0] data;
        bit          ok;
        do_write(4'h4, 32'hFFFFFFFF, 4'hF, pulse, resp, ok);
        do_write(4'h4, 32'h000000AA, 4'b0001, pulse, resp, ok);
        checks++;
        if (!ok || pulse !== 4'b0010) begin
            failures++;
            $display("FAIL strobe_pulse: got ok=%0d pulse=%b expected 1/0010", ok, pulse);
        end
        do_read(4'h4, data, ok);
        checks++;
        if (!ok || data !== 32'hFFFFFFAA) begin
            failures++;
            $display("FAIL strobe_read: got %h expected FFFFFFAA", data);
        end
        do_write(4'h4, 32'h12345678, 4'b0000, pulse, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00 || pulse !== 4'b0000) begin
            failures++;
            $display("FAIL strobe_zero: got ok=%0d bresp=%b pulse=%b expected 1/00/0000", ok, resp, pulse);
        end
        do_read(4'h4, data, ok);
        checks++;
        if (!ok || data !== 32'hFFFFFFAA) begin
            failures++;
            $display("FAIL strobe_zero_read: got %h expected FFFFFFAA", data);
        end
        do_write(4'h7, 32'h0000BB00, 4'b0010, pulse, resp, ok);
        do_read(4'h5, data, ok);
        checks++;
        if (!ok || pulse !== 4'b0010 || data !== 32'hFFFFBBAA) begin
            failures++;
            $display("FAIL unaligned_addr: got pulse=%b data=%h expected 0010/FFFFBBAA", pulse, data);
        end
    endtask

    task automatic test_aw_first();
        logic [31:0] data;
        bit          ok;
        bready = 1'b1;
        awaddr = 4'h8; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0 || reg_wr_pulse !== 4'b0) begin
            failures++;
            $display("FAIL aw_first_wait: got awready=%b wready=%b bvalid=%b pulse=%b expected 0/1/0/0000",
                     awready, wready, bvalid, reg_wr_pulse);
        end
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_wr_pulse !== 4'b0100 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL aw_first_commit: got pulse=%b bvalid=%b expected 0100/0", reg_wr_pulse, bvalid);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || reg2_out !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL aw_first_resp: got bvalid=%b reg2=%h expected 1/DEADBEEF", bvalid, reg2_out);
        end
        tick();
        do_read(4'h8, data, ok);
        checks++;
        if (!ok || data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL aw_first_read: got %h expected DEADBEEF", data);
        end
    endtask

    task automatic test_w_first();
        logic [31:0] data;
        bit          ok;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL w_first_wait: got awready=%b wready=%b bvalid=%b expected 1/0/0",
                     awready, wready, bvalid);
        end
        awaddr = 4'hC; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_wr_pulse !== 4'b1000) begin
            failures++;
            $display("FAIL w_first_commit: got pulse=%b expected 1000", reg_wr_pulse);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || reg3_out !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL w_first_resp: got bvalid=%b reg3=%h expected 1/CAFEF00D", bvalid, reg3_out);
        end
        tick();
        do_read(4'hC, data, ok);
        checks++;
        if (!ok || data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL w_first_read: got %h expected CAFEF00D", data);
        end
    endtask

    task automatic test_bready_stall();
        logic [3:0] pulse;
        bit         ok;
        bready = 1'b0;
        awaddr = 4'h8; wdata = 32'h13572468; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL stall_bvalid_rise: got %b expected 1", bvalid);
        end
        wdata = 32'h2468ACE0; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 ||
                reg_wr_pulse !== 4'b0 || reg2_out !== 32'h13572468) begin
                failures++;
                $display("FAIL stall_cycle%0d: got bvalid=%b awready=%b wready=%b pulse=%b reg2=%h expected 1/0/0/0000/13572468",
                         i, bvalid, awready, wready, reg_wr_pulse, reg2_out);
            end
        end
        bready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || reg2_out !== 32'h13572468) begin
            failures++;
            $display("FAIL stall_release: got bvalid=%b awready=%b wready=%b reg2=%h expected 0/1/1/13572468",
                     bvalid, awready, wready, reg2_out);
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        pulse = 4'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulse = pulse | reg_wr_pulse;
            if (bvalid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || pulse !== 4'b0100 || reg2_out !== 32'h2468ACE0) begin
            failures++;
            $display("FAIL stall_next_write: got ok=%0d pulse=%b reg2=%h expected 1/0100/2468ACE0",
                     ok, pulse, reg2_out);
        end
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] data;
        bit          ok;
        bready = 1'b1; rready = 1'b0;
        awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h1 || reg0_out !== 32'h55) begin
            failures++;
            $display("FAIL collision_capture: got rvalid=%b rdata=%h reg0=%h expected 1/00000001/00000055",
                     rvalid, rdata, reg0_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h1 || arready !== 1'b0) begin
                failures++;
                $display("FAIL collision_hold%0d: got rvalid=%b rdata=%h arready=%b expected 1/00000001/0",
                         i, rvalid, rdata, arready);
            end
        end
        rready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            failures++;
            $display("FAIL collision_release: got rvalid=%b arready=%b expected 0/1", rvalid, arready);
        end
        do_read(4'h0, data, ok);
        checks++;
        if (!ok || data !== 32'h55) begin
            failures++;
            $display("FAIL collision_next_read: got %h expected 00000055", data);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] data;
        bit          ok;
        bready = 1'b0; rready = 1'b0;
        awaddr = 4'h4; wdata = 32'h11; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL mid_pending: got bvalid=%b rvalid=%b rdata=%h expected 1/1/CAFEF00D",
                     bvalid, rvalid, rdata);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0 ||
            reg_wr_pulse !== 4'b0 || reg0_out !== 32'h0 || reg1_out !== 32'h0 ||
            reg2_out !== 32'h0 || reg3_out !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got hs=%b rdata=%h pulse=%b regs=%h/%h/%h/%h expected all zero",
                     {awready, wready, arready, bvalid, rvalid}, rdata, reg_wr_pulse,
                     reg0_out, reg1_out, reg2_out, reg3_out);
        end
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            failures++;
            $display("FAIL mid_ready_before_edge: got %b expected 000", {awready, wready, arready});
        end
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_ready_after_edge: got ready=%b bvalid=%b rvalid=%b expected 111/0/0",
                     {awready, wready, arready}, bvalid, rvalid);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), data, ok);
            checks++;
            if (!ok || data !== 32'h0) begin
                failures++;
                $display("FAIL mid_read%0d: got ok=%0d data=%h expected 00000000", i, ok, data);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        test_reset();
        test_write_latency();
        test_sequential();
        test_strobe();
        test_aw_first();
        test_w_first();
        test_bready_stall();
        test_collision();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
